branch_ctrl: RTL and testbench
==============================

# branch_ctrl

ID-stage branch resolution controller for the pipelined MIPS core. It sits beside the 32-bit equality comparator that resolves beq/bne in decode. It detects data hazards on the comparator operands, stalls the front end until they clear, and selects forwarding for the comparator inputs. It then issues the PC redirect and the IF/ID flush for taken branches, and masks the bubble that follows a redirect.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 2, width of stall-cycle counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_beq  in  1  instruction in ID is beq
- id_bne  in  1  instruction in ID is bne
- id_rs  in  REG_W  ID source register A
- id_rt  in  REG_W  ID source register B
- ex_reg_write  in  1  instruction in EX writes a register
- ex_rd  in  REG_W  destination of EX instruction
- mem_reg_write  in  1  instruction in MEM writes a register
- mem_mem_read  in  1  instruction in MEM is a load
- mem_rd  in  REG_W  destination of MEM instruction
- cmp_equal  in  1  comparator result (1 = operands equal)
- stall  out  1  hold PC and IF/ID, bubble into ID/EX
- pc_src  out  1  select branch target for next PC
- if_flush  out  1  clear IF/ID at next edge
- fwd_a  out  1  comparator A input: 0 = register file, 1 = EX/MEM ALU result
- fwd_b  out  1  same for input B
- stall_cnt  out  CNT_W  stall cycles spent on the current branch

## Operation
- Branch present: br = id_beq | id_bne. Both high is illegal and is treated as beq.
- Taken: beq → cmp_equal; bne → !cmp_equal.
- Per-operand match (register r ≠ 0):
  - ex_hit = ex_reg_write & ex_rd==r
  - ld_hit = mem_mem_read & mem_rd==r
  - alu_hit = mem_reg_write & !mem_mem_read & mem_rd==r
- hazard = br & (ex_hit or ld_hit on rs or rt). Register $0 never hazards and never forwards.
- fwd_a = alu_hit(rs) & !ex_hit(rs). fwd_b is the same for rt.
- Register file is write-before-read, so WB-stage producers need no handling.
- FSM states:
  - RUN: normal operation.
    - br & hazard → stall=1, go to HSTALL.
    - br & !hazard & taken → pc_src=1, if_flush=1, go to FLUSH.
    - Otherwise stay in RUN.
  - HSTALL: the same instruction is held in ID and the hazard is re-evaluated each cycle.
    - Still hazard → stall=1, stall_cnt increments (saturating).
    - Clear and taken → pc_src=1, if_flush=1, go to FLUSH.
    - Clear and not taken → go to RUN.
    - br deasserted → go to RUN.
  - FLUSH: one cycle. The ID slot holds the flushed bubble, so br is ignored and all outputs except fwd_* are 0. Always go to RUN.
- stall_cnt clears on every exit from HSTALL and holds 0 in RUN and FLUSH.
- Maximum hazard length by construction:
  - ALU producer in EX: 1 stall.
  - Load in EX: 2 stalls (EX, then MEM load).
  - Load in MEM: 1 stall.

## Timing
- Reset (async): state=RUN, stall_cnt=0, and stall, pc_src and if_flush are all 0 immediately, independent of clk. fwd_* remain combinational from the inputs.
- stall, pc_src, if_flush and fwd_* are combinational from the current state and inputs, valid in the same cycle the branch occupies ID.
- Redirect latency: pc_src is asserted in the resolve cycle; the target is fetched on the next edge.
- stall and pc_src are never high in the same cycle.
- Reset mid-HSTALL or mid-FLUSH: the FSM returns to RUN and the pending branch is dropped.
- Back-to-back branches: a branch arriving in the cycle after a not-taken resolve is evaluated normally in RUN.

## Configuration
- BRANCH_FWD_EN:
  - Defined: forwarding behaves as described in Operation.
  - Undefined: fwd_a=fwd_b=0 constantly, and alu_hit is added to the hazard condition. An ALU producer in MEM then costs 1 stall instead of being forwarded, and the maximum stall count remains 2.

## Test plan
- Reset mid-stall: rst asserted while in HSTALL → stall=0 before the next edge, stall_cnt=0; after release, branch with no hazard resolves in one cycle.
- EX ALU hazard: beq rs=3, ex_reg_write=1, ex_rd=3 → stall=1 for exactly 1 cycle, stall_cnt=1. Next cycle: MEM alu_hit gives fwd_a=1; with cmp_equal=1 → pc_src=1, if_flush=1.
- Load-use: bne rt=7, load in EX with ex_rd=7 → stall for 2 cycles (stall_cnt 1 then 2). Resolves with cmp_equal=1 → pc_src=0, back to RUN, stall_cnt=0.
- $0 operand: beq rs=0, ex_rd=0, ex_reg_write=1 → no stall, fwd_a=0.
- Taken then bubble: beq taken in cycle N → pc_src=if_flush=1 in N. In N+1 the FSM is in FLUSH, so id_beq=1 held on the input gives pc_src=0 and stall=0.
- BRANCH_FWD_EN undefined: beq rs=5, mem_reg_write=1, mem_rd=5, load not set → 1 stall cycle, fwd_a=0 throughout.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution controller.
// Detects comparator-operand hazards, stalls the front end until they clear,
// selects EX/MEM forwarding for the comparator inputs, and issues the PC
// redirect plus IF/ID flush for taken beq/bne branches.
// Optional feature macro: BRANCH_FWD_EN
//   defined   -> ALU results in MEM are forwarded to the comparator
//   undefined -> no forwarding; an ALU producer in MEM stalls instead
module branch_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_beq,
    input  logic             id_bne,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             cmp_equal,
    output logic             stall,
    output logic             pc_src,
    output logic             if_flush,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic br, taken, hazard;
    logic ex_hit_a, ex_hit_b, ld_hit_a, ld_hit_b, alu_hit_a, alu_hit_b;
    logic stall_c, redirect_c;

    // Register $0 is hard-wired to zero, so it can never match a producer.
    function automatic logic reg_match(input logic en,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] r);
        return en && (r != '0) && (rd == r);
    endfunction

    // Operand match terms against the EX and MEM producers.
    always_comb begin
        br        = id_beq | id_bne;
        // beq wins when both are set, so taken follows the beq sense.
        taken     = id_beq ? cmp_equal : ~cmp_equal;
        ex_hit_a  = reg_match(ex_reg_write, ex_rd, id_rs);
        ex_hit_b  = reg_match(ex_reg_write, ex_rd, id_rt);
        ld_hit_a  = reg_match(mem_mem_read, mem_rd, id_rs);
        ld_hit_b  = reg_match(mem_mem_read, mem_rd, id_rt);
        alu_hit_a = reg_match(mem_reg_write & ~mem_mem_read, mem_rd, id_rs);
        alu_hit_b = reg_match(mem_reg_write & ~mem_mem_read, mem_rd, id_rt);
`ifdef BRANCH_FWD_EN
        hazard    = br & (ex_hit_a | ld_hit_a | ex_hit_b | ld_hit_b);
        // A younger EX producer of the same register takes priority.
        fwd_a     = alu_hit_a & ~ex_hit_a;
        fwd_b     = alu_hit_b & ~ex_hit_b;
`else
        hazard    = br & (ex_hit_a | ld_hit_a | alu_hit_a |
                          ex_hit_b | ld_hit_b | alu_hit_b);
        fwd_a     = 1'b0;
        fwd_b     = 1'b0;
`endif
    end

    // Next-state, stall counter and unregistered control decode.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = '0;
        stall_c     = 1'b0;
        redirect_c  = 1'b0;
        case (state_q)
            RUN: begin
                if (br && hazard) begin
                    stall_c     = 1'b1;
                    stall_cnt_d = CNT_W'(1);
                    state_d     = HSTALL;
                end else if (br && taken) begin
                    redirect_c  = 1'b1;
                    state_d     = FLUSH;
                end
            end
            HSTALL: begin
                if (!br) begin
                    state_d     = RUN;
                end else if (hazard) begin
                    stall_c     = 1'b1;
                    stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q
                                                      : stall_cnt_q + 1'b1;
                end else if (taken) begin
                    redirect_c  = 1'b1;
                    state_d     = FLUSH;
                end else begin
                    state_d     = RUN;
                end
            end
            FLUSH: begin
                // ID holds the flushed bubble; any branch decode is stale.
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Control outputs are forced low while reset is asserted, without waiting for clk.
    always_comb begin
        stall     = stall_c & ~rst;
        pc_src    = redirect_c & ~rst;
        if_flush  = redirect_c & ~rst;
        stall_cnt = stall_cnt_q;
    end

    // State and stall counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed bench for branch_ctrl with a behavioural model.
// Follows BRANCH_FWD_EN the same way as the design build.
module tb_branch_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;
`ifdef BRANCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             id_beq, id_bne;
    logic [REG_W-1:0] id_rs, id_rt;
    logic             ex_reg_write;
    logic [REG_W-1:0] ex_rd;
    logic             mem_reg_write, mem_mem_read;
    logic [REG_W-1:0] mem_rd;
    logic             cmp_equal;
    logic             stall, pc_src, if_flush, fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: stall cycles already spent on the branch in ID, and
    // whether the ID slot currently holds the bubble behind a redirect.
    int m_wait   = 0;
    bit m_bubble = 1'b0;

    branch_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_beq(id_beq), .id_bne(id_bne), .id_rs(id_rs), .id_rt(id_rt),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .cmp_equal(cmp_equal),
        .stall(stall), .pc_src(pc_src), .if_flush(if_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    function automatic bit m_hz(input logic [REG_W-1:0] r);
        if (r == 0) return 1'b0;
        if (ex_reg_write && ex_rd == r) return 1'b1;
        if (mem_mem_read && mem_rd == r) return 1'b1;
        if (!FWD && mem_reg_write && !mem_mem_read && mem_rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_fwd(input logic [REG_W-1:0] r);
        if (!FWD || r == 0) return 1'b0;
        if (ex_reg_write && ex_rd == r) return 1'b0;
        return mem_reg_write && !mem_mem_read && mem_rd == r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic compare_now(input string tag);
        bit br, hz, tk, live;
        br   = id_beq | id_bne;
        hz   = m_hz(id_rs) | m_hz(id_rt);
        tk   = id_beq ? cmp_equal : !cmp_equal;
        live = !rst && !m_bubble && br;
        chk({tag, ".stall"},    int'(stall),     int'(live && hz));
        chk({tag, ".pc_src"},   int'(pc_src),    int'(live && !hz && tk));
        chk({tag, ".if_flush"}, int'(if_flush),  int'(live && !hz && tk));
        chk({tag, ".fwd_a"},    int'(fwd_a),     int'(m_fwd(id_rs)));
        chk({tag, ".fwd_b"},    int'(fwd_b),     int'(m_fwd(id_rt)));
        chk({tag, ".cnt"},      int'(stall_cnt), rst ? 0 : m_wait);
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        compare_now(tag);
    endtask

    task automatic advance();
        bit br, hz, tk, live;
        @(posedge clk);
        if (rst) begin
            m_wait   = 0;
            m_bubble = 1'b0;
        end else begin
            br   = id_beq | id_bne;
            hz   = m_hz(id_rs) | m_hz(id_rt);
            tk   = id_beq ? cmp_equal : !cmp_equal;
            live = !m_bubble && br;
            m_bubble = live && !hz && tk;
            m_wait   = (live && hz) ? ((m_wait < 3) ? m_wait + 1 : 3) : 0;
        end
        #1;
    endtask

    task automatic drive(input logic b, input logic n, input int rs, input int rt,
                         input logic exw, input int exrd, input logic mw,
                         input logic ml, input int mrd, input logic eq);
        id_beq        = b;
        id_bne        = n;
        id_rs         = rs[REG_W-1:0];
        id_rt         = rt[REG_W-1:0];
        ex_reg_write  = exw;
        ex_rd         = exrd[REG_W-1:0];
        mem_reg_write = mw;
        mem_mem_read  = ml;
        mem_rd        = mrd[REG_W-1:0];
        cmp_equal     = eq;
    endtask

    task automatic idle_cycle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(tag);
        advance();
    endtask

    initial begin
        // Reset with a hazarding branch on the inputs: controls stay low.
        rst = 1'b1;
        drive(1, 0, 3, 0, 1, 3, 0, 0, 0, 1);
        #2;
        compare_now("rst");
        chk("rst_stall", int'(stall), 0);
        chk("rst_pc", int'(pc_src), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // $0 operand never hazards or forwards.
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        settle("zero");
        chk("zero_stall", int'(stall), 0);
        chk("zero_fwd", int'(fwd_a), 0);
        advance();

        // Taken, then bubble with the branch still on the inputs, then taken again.
        drive(1, 0, 1, 2, 0, 0, 0, 0, 0, 1);
        settle("tk");
        chk("tk_pc", int'(pc_src), 1);
        chk("tk_flush", int'(if_flush), 1);
        advance();
        settle("bub");
        chk("bub_pc", int'(pc_src), 0);
        chk("bub_stall", int'(stall), 0);
        chk("bub_flush", int'(if_flush), 0);
        advance();
        settle("tk2");
        chk("tk2_pc", int'(pc_src), 1);
        advance();
        idle_cycle("bub2");

        // ALU producer in EX, then in MEM, then retired.
        drive(1, 0, 3, 4, 1, 3, 0, 0, 0, 1);
        settle("exalu1");
        chk("exalu1_stall", int'(stall), 1);
        chk("exalu1_cnt", int'(stall_cnt), 0);
        advance();
        drive(1, 0, 3, 4, 0, 0, 1, 0, 3, 1);
        settle("exalu2");
        chk("exalu2_cnt", int'(stall_cnt), 1);
`ifdef BRANCH_FWD_EN
        chk("exalu2_fwd", int'(fwd_a), 1);
        chk("exalu2_pc", int'(pc_src), 1);
        chk("exalu2_stall", int'(stall), 0);
`else
        chk("exalu2_fwd", int'(fwd_a), 0);
        chk("exalu2_stall", int'(stall), 1);
`endif
        advance();
        drive(1, 0, 3, 4, 0, 0, 0, 0, 0, 1);
        settle("exalu3");
`ifdef BRANCH_FWD_EN
        chk("exalu3_pc", int'(pc_src), 0);
        chk("exalu3_cnt", int'(stall_cnt), 0);
`else
        chk("exalu3_pc", int'(pc_src), 1);
        chk("exalu3_cnt", int'(stall_cnt), 2);
`endif
        advance();
        idle_cycle("exalu4");

        // Load-use on rt for bne, resolving not taken; then back-to-back beq.
        drive(0, 1, 6, 7, 1, 7, 0, 0, 0, 1);
        settle("ld1");
        chk("ld1_stall", int'(stall), 1);
        chk("ld1_cnt", int'(stall_cnt), 0);
        advance();
        drive(0, 1, 6, 7, 0, 0, 1, 1, 7, 1);
        settle("ld2");
        chk("ld2_stall", int'(stall), 1);
        chk("ld2_cnt", int'(stall_cnt), 1);
        advance();
        drive(0, 1, 6, 7, 0, 0, 0, 0, 0, 1);
        settle("ld3");
        chk("ld3_stall", int'(stall), 0);
        chk("ld3_pc", int'(pc_src), 0);
        chk("ld3_cnt", int'(stall_cnt), 2);
        advance();
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        settle("b2b");
        chk("b2b_pc", int'(pc_src), 1);
        chk("b2b_cnt", int'(stall_cnt), 0);
        advance();
        idle_cycle("b2b_bub");

        // ALU producer already in MEM.
        drive(1, 0, 5, 0, 0, 0, 1, 0, 5, 0);
        settle("memalu1");
        chk("memalu1_fwd", int'(fwd_a), FWD ? 1 : 0);
        chk("memalu1_stall", int'(stall), FWD ? 0 : 1);
        advance();
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        settle("memalu2");
        chk("memalu2_stall", int'(stall), 0);
        chk("memalu2_fwd", int'(fwd_a), 0);
        chk("memalu2_cnt", int'(stall_cnt), FWD ? 0 : 1);
        advance();
        idle_cycle("memalu3");

        // beq and bne both high behave as beq.
        drive(1, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        settle("both0");
        chk("both0_pc", int'(pc_src), 0);
        advance();
        drive(1, 1, 2, 3, 0, 0, 0, 0, 0, 1);
        settle("both1");
        chk("both1_pc", int'(pc_src), 1);
        advance();
        idle_cycle("both_bub");

        // Persistent hazard saturates the counter; dropping br releases it.
        drive(1, 0, 9, 0, 1, 9, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            settle("sat");
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle("satx");
        chk("sat_cnt", int'(stall_cnt), 3);
        chk("satx_stall", int'(stall), 0);
        advance();
        settle("satr");
        chk("satr_cnt", int'(stall_cnt), 0);
        advance();

        // Reset asserted mid-stall clears controls before the next edge.
        drive(1, 0, 3, 0, 1, 3, 0, 0, 0, 1);
        settle("rs1");
        advance();
        settle("rs2");
        chk("rs2_stall", int'(stall), 1);
        chk("rs2_cnt", int'(stall_cnt), 1);
        #2;
        rst      = 1'b1;
        m_wait   = 0;
        m_bubble = 1'b0;
        #1;
        compare_now("rstmid");
        chk("rstmid_stall", int'(stall), 0);
        chk("rstmid_cnt", int'(stall_cnt), 0);
        advance();
        rst = 1'b0;
        drive(1, 0, 1, 2, 0, 0, 0, 0, 0, 1);
        settle("post");
        chk("post_pc", int'(pc_src), 1);
        chk("post_stall", int'(stall), 0);
        advance();
        idle_cycle("post_bub");

        // Load in MEM on rt costs one stall.
        drive(1, 0, 0, 10, 0, 0, 1, 1, 10, 0);
        settle("ldmem1");
        chk("ldmem1_stall", int'(stall), 1);
        advance();
        drive(1, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        settle("ldmem2");
        chk("ldmem2_stall", int'(stall), 0);
        chk("ldmem2_cnt", int'(stall_cnt), 1);
        advance();

        // EX producer shadows a MEM ALU producer of the same register.
        drive(1, 0, 0, 11, 1, 11, 1, 0, 11, 0);
        settle("shadow");
        chk("shadow_fwd", int'(fwd_b), 0);
        chk("shadow_stall", int'(stall), 1);
        advance();
        idle_cycle("shadow_end");

        // Mixed vectors over a small register range, checked by the model.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            settle("mix");
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
